// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit add/subtract engine: loads two operands, streams them LSB-first, assembles the sum.
// Latency: Done is high in the cycle after the WIDTH-th edge following the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: Start is accepted only while Ready (IDLE); it is ignored, not queued, in RUN and DONE.
//
// Ports:
//   Clk, Rst_n            clock and asynchronous active-low reset
//   Start, Sub            request strobe and add(0)/subtract(1) select, sampled on the accepting edge
//   Op_A, Op_B            parallel operands, sampled on the accepting edge
//   Ready, Busy, Done     IDLE / RUN indicators and the one-cycle completion pulse
//   Result, Carry_Out,    parallel sum/difference, carry out of the MSB (1 = no borrow on Sub),
//   Overflow              and two's-complement overflow; all held until the next Done
//   Bit_A, Bit_B, Bit_En  serial bit stream and enable for the downstream one-bit adder cell
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] Op_A,
    input  logic [WIDTH-1:0] Op_B,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry_Out,
    output logic             Overflow,
    output logic             Bit_A,
    output logic             Bit_B,
    output logic             Bit_En
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Only the upper WIDTH-1 result bits need storage: the final sum bit goes
    // straight into Result on the last edge, so r_sr[0] would never be read.
    logic [WIDTH-1:1]   r_sr_q, r_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               sum_bit;
    logic               carry_nxt;
    logic [WIDTH-1:0]   r_full;

    // One-bit full adder on the shift-register LSBs.
    assign sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // Result register after this edge's shift: new bit enters at the MSB.
    assign r_full    = {sum_bit, r_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        r_sr_d   = r_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_sr_d  = Op_A;
                    // Subtraction is A + ~B + 1: invert B here, carry-in of 1.
                    b_sr_d  = Sub ? ~Op_B : Op_B;
                    r_sr_d  = '0;
                    carry_d = Sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                r_sr_d  = r_full[WIDTH-1:1];
                carry_d = carry_nxt;
                if (cnt_q == LAST_BIT) begin
                    result_d = r_full;
                    cout_d   = carry_nxt;
                    // carry_q is the carry into the MSB on this edge.
                    ovf_d    = carry_q ^ carry_nxt;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            r_sr_q   <= r_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Ready     = (state_q == S_IDLE);
    assign Busy      = (state_q == S_RUN);
    assign Done      = (state_q == S_DONE);
    assign Bit_En    = Busy;
    assign Bit_A     = Busy & a_sr_q[0];
    assign Bit_B     = Busy & b_sr_q[0];
    assign Result    = result_q;
    assign Carry_Out = cout_q;
    assign Overflow  = ovf_q;

endmodule
